// File: rtl/float_discriminant_collector_pkg.sv
// Shared types and sizes for the discriminant result collector.
// Contents: float width, FIFO depth, counter-width helper, FIFO entry struct.
package float_discriminant_collector_pkg;

  localparam int unsigned FLEN  = 64;
  localparam int unsigned DEPTH = 8;

  // Bits needed to count 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  typedef struct packed {
    logic            err;
    logic            negative;
    logic [FLEN-1:0] value;
  } disc_entry_t;

endpackage

// File: rtl/float_discriminant_res_fifo.sv
// Flip-flop FIFO of discriminant entries, show-ahead read, wrap-bit pointers.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i, wdata_i write request and entry (dropped when full with no pop)
//   pop_i           read request (ignored when empty)
//   rdata_o         head entry, mem[rd_ptr]
//   full_o, empty_o occupancy flags
//   level_o         occupancy 0..DEPTH_P
module float_discriminant_res_fifo
  import float_discriminant_collector_pkg::*;
#(
  parameter int unsigned DEPTH_P = DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  disc_entry_t                      wdata_i,
  output disc_entry_t                      rdata_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [$clog2(DEPTH_P+1)-1:0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH_P);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH_P + 1);

  disc_entry_t   mem_q [DEPTH_P];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  // Full: same slot index, opposite lap; empty: identical pointers.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = wr_ptr_q + PW'(do_push);
  assign rd_ptr_d = rd_ptr_q + PW'(do_pop);

  assign level_o = LW'(wr_ptr_q - rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/float_discriminant_res_collector.sv
// Collects the valid-only discriminant result stream into an in-order FIFO
// and re-presents it over valid/ready. Credits the argument source so every
// returning result is guaranteed a slot.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   arg_vld / arg_rdy              argument issue tap / credit to source
//   res_vld, res, res_negative,err distributor result stream (no backpressure)
//   out_vld/out_rdy, out_res,
//   out_negative, out_err          consumer handshake and head entry
//   level, inflight                FIFO occupancy, outstanding arguments
//   proto_err                      sticky protocol-violation flag
module float_discriminant_res_collector
  import float_discriminant_collector_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic             res_vld,
  input  logic [FLEN-1:0]  res,
  input  logic             res_negative,
  input  logic             err,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [FLEN-1:0]  out_res,
  output logic             out_negative,
  output logic             out_err,
  output logic [CNT_W-1:0] level,
  output logic [CNT_W-1:0] inflight
  ,output logic            proto_err
);

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] level_w;
  logic [CNT_W:0]   credit_sum;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  disc_entry_t      wr_entry;
  disc_entry_t      head;

  assign wr_entry = '{err: err, negative: res_negative, value: res};

  float_discriminant_res_fifo #(
    .DEPTH_P (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (res_vld),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_w)
  );

  // Credit depends on registered counts only, never on this cycle's inputs.
  assign credit_sum = (CNT_W+1)'(level_w) + (CNT_W+1)'(inflight_q);
  assign arg_rdy    = !rst && (credit_sum < (CNT_W+1)'(DEPTH));

  assign out_vld      = !rst && !fifo_empty;
  assign pop          = out_vld && out_rdy;
  assign out_res      = head.value;
  assign out_negative = head.negative;
  assign out_err      = head.err;
  assign level        = level_w;
  assign inflight     = inflight_q;
  assign proto_err    = proto_err_q;

  // Outstanding-argument count and violation detection.
  always_comb begin
    inflight_d  = inflight_q;
    proto_err_d = proto_err_q;

    if (arg_vld && !res_vld) begin
      // Saturate so an over-issuing source cannot wrap the counter.
      if (inflight_q != CNT_W'(DEPTH)) begin
        inflight_d = inflight_q + CNT_W'(1);
      end
    end else if (res_vld && !arg_vld) begin
      if (inflight_q != '0) begin
        inflight_d = inflight_q - CNT_W'(1);
      end
    end

    if (arg_vld && !arg_rdy) begin
      proto_err_d = 1'b1;
    end
    if (res_vld && (inflight_q == '0)) begin
      proto_err_d = 1'b1;
    end
    if (res_vld && fifo_full && !pop) begin
      proto_err_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_float_discriminant_res_collector.sv
// Directed bench for the discriminant result collector: queue-based model
// checked every cycle, plus literal expectations at key points.
module tb_float_discriminant_res_collector;
  import float_discriminant_collector_pkg::*;

  localparam int D = int'(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             arg_vld;
  logic             arg_rdy;
  logic             res_vld;
  logic [FLEN-1:0]  res;
  logic             res_negative;
  logic             err;
  logic             out_vld;
  logic             out_rdy;
  logic [FLEN-1:0]  out_res;
  logic             out_negative;
  logic             out_err;
  logic [CNT_W-1:0] level;
  logic [CNT_W-1:0] inflight;
  logic             proto_err;

  disc_entry_t mq[$];
  int          m_infl = 0;
  bit          m_perr = 1'b0;
  int          n_vec  = 0;
  int          n_bad  = 0;
  bit          done   = 1'b0;

  always #5 clk = ~clk;

  float_discriminant_res_collector dut (
    .clk          (clk),
    .rst          (rst),
    .arg_vld      (arg_vld),
    .arg_rdy      (arg_rdy),
    .res_vld      (res_vld),
    .res          (res),
    .res_negative (res_negative),
    .err          (err),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_res      (out_res),
    .out_negative (out_negative),
    .out_err      (out_err),
    .level        (level),
    .inflight     (inflight),
    .proto_err    (proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, in-flight as an integer, all rules applied per edge.
  task automatic model_step();
    bit rdy, pop, full;
    disc_entry_t e;
    if (rst) begin
      mq.delete();
      m_infl = 0;
      m_perr = 1'b0;
    end else begin
      rdy  = (mq.size() + m_infl) < D;
      pop  = (mq.size() != 0) && out_rdy;
      full = (mq.size() == D);
      if (arg_vld && !rdy) m_perr = 1'b1;
      if (res_vld && m_infl == 0) m_perr = 1'b1;
      if (pop) void'(mq.pop_front());
      if (res_vld) begin
        if (!full || pop) begin
          e.err = err; e.negative = res_negative; e.value = res;
          mq.push_back(e);
        end else begin
          m_perr = 1'b1;
        end
      end
      if (arg_vld && !res_vld) begin
        if (m_infl < D) m_infl++;
      end else if (res_vld && !arg_vld) begin
        if (m_infl > 0) m_infl--;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  initial begin
    bit exp_vld;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (done) break;
      exp_vld = !rst && (mq.size() != 0);
      chk("out_vld", 64'(out_vld), 64'(exp_vld));
      if (exp_vld) begin
        chk("out_res", out_res, mq[0].value);
        chk("out_negative", 64'(out_negative), 64'(mq[0].negative));
        chk("out_err", 64'(out_err), 64'(mq[0].err));
      end
      chk("level", 64'(level), 64'(mq.size()));
      chk("inflight", 64'(inflight), 64'(m_infl));
      chk("arg_rdy", 64'(arg_rdy), 64'(!rst && ((mq.size() + m_infl) < D)));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
    end
  end

  task automatic step(input logic av, input logic rv, input logic [63:0] v,
                      input logic ng, input logic e, input logic ordy);
    arg_vld = av; res_vld = rv; res = v; res_negative = ng; err = e; out_rdy = ordy;
    @(posedge clk);
    #1;
    arg_vld = 1'b0; res_vld = 1'b0; out_rdy = 1'b0; res_negative = 1'b0; err = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; arg_vld = 1'b0; res_vld = 1'b0; res = '0;
    res_negative = 1'b0; err = 1'b0; out_rdy = 1'b0;
    idle();
    idle();
    rst = 1'b0;
    #1;
    chk("rst arg_rdy", 64'(arg_rdy), 64'd1);
    chk("rst level", 64'(level), 64'd0);
    chk("rst inflight", 64'(inflight), 64'd0);
    chk("rst out_vld", 64'(out_vld), 64'd0);
    chk("rst proto_err", 64'(proto_err), 64'd0);

    // Single result: 4^2 - 4*1*3 = 4.0
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h4010_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    chk("single out_vld", 64'(out_vld), 64'd1);
    chk("single out_res", out_res, 64'h4010_0000_0000_0000);
    chk("single flags", 64'({out_negative, out_err}), 64'd0);
    chk("single level", 64'(level), 64'd1);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("single drained", 64'(level), 64'd0);

    // Ordering of negative, NaN/err and zero results.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hC008_0000_0000_0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h7FF8_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("order level", 64'(level), 64'd3);
    chk("order h0", {out_negative, out_err, out_res[61:0]}, {2'b10, 62'h0008_0000_0000_0000});
    chk("order h0 hi", 64'(out_res[63:62]), 64'd3);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("order h1", out_res, 64'h7FF8_0000_0000_0000);
    chk("order h1 flags", 64'({out_negative, out_err}), 64'd1);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("order h2", out_res, 64'h0);
    chk("order h2 flags", 64'({out_negative, out_err}), 64'd0);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("order drained", 64'(level), 64'd0);

    // Credit stall.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("credit arg_rdy", 64'(arg_rdy), 64'd0);
    chk("credit inflight", 64'(inflight), 64'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 64'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("credit level", 64'(level), 64'd8);
    chk("credit inflight0", 64'(inflight), 64'd0);
    chk("credit still stalled", 64'(arg_rdy), 64'd0);
    chk("credit proto_err", 64'(proto_err), 64'd0);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("credit reopen", 64'(arg_rdy), 64'd1);
    chk("credit level7", 64'(level), 64'd7);

    // Full FIFO with simultaneous push/pop, a drop, then drain across a wrap.
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'd100, 1'b0, 1'b0, 1'b0);
    chk("full level", 64'(level), 64'd8);
    chk("full proto_err", 64'(proto_err), 64'd0);
    step(1'b0, 1'b1, 64'd101, 1'b0, 1'b0, 1'b1);
    chk("full pushpop level", 64'(level), 64'd8);
    chk("full pushpop head", out_res, 64'd3);
    chk("unexpected res proto_err", 64'(proto_err), 64'd1);
    step(1'b0, 1'b1, 64'd102, 1'b0, 1'b0, 1'b0);
    chk("drop level", 64'(level), 64'd8);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 64'(200 + i), 1'b0, 1'b0, 1'b1);
    chk("wrap head", out_res, 64'd204);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("wrap drained", 64'(level), 64'd0);
    chk("sticky proto_err", 64'(proto_err), 64'd1);

    // Violations.
    do_reset();
    chk("viol cleared", 64'(proto_err), 64'd0);
    step(1'b0, 1'b1, 64'd5, 1'b0, 1'b0, 1'b0);
    chk("viol unexpected", 64'(proto_err), 64'd1);
    chk("viol still pushed", 64'(level), 64'd1);
    idle(); idle(); idle();
    chk("viol sticky", 64'(proto_err), 64'd1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("viol pre over-issue", 64'(proto_err), 64'd0);
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("viol over-issue", 64'(proto_err), 64'd1);
    chk("viol inflight sat", 64'(inflight), 64'd8);
    idle();
    chk("viol over-issue sticky", 64'(proto_err), 64'd1);

    // Reset mid-stream.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 64'(300 + i), 1'b0, 1'b0, 1'b0);
    chk("mid level", 64'(level), 64'd5);
    chk("mid inflight", 64'(inflight), 64'd3);
    do_reset();
    chk("mid rst level", 64'(level), 64'd0);
    chk("mid rst inflight", 64'(inflight), 64'd0);
    chk("mid rst out_vld", 64'(out_vld), 64'd0);
    chk("mid rst arg_rdy", 64'(arg_rdy), 64'd1);
    step(1'b0, 1'b1, 64'd999, 1'b0, 1'b0, 1'b0);
    chk("stale result", 64'(proto_err), 64'd1);
    idle();

    done = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
